// File: rtl/riscky_pkg.sv
// riscky_pkg: shared core constants plus the fetch-side types.
//   XLEN/ILEN        : address and instruction widths
//   IMEM_WORDS       : number of implemented instruction-memory words
//   IMEM_AW          : instruction-memory word-index width
//   fetch_state_t    : fetch sequencer states
//   fetch_entry_t    : one fetch-queue entry {pc, instr}
package riscky_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned ILEN             = 32;
  localparam int unsigned IMEM_WORDS       = 16;
  localparam int unsigned IMEM_AW          = 4;
  localparam int unsigned FQ_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // True when a word index (byte address >> 2) hits implemented memory.
  function automatic logic imem_word_ok(logic [XLEN-3:0] word_idx);
    return word_idx < (XLEN-2)'(IMEM_WORDS);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundle of the fetch unit's memory, redirect and decode-side signals.
//   imem_addr/imem_rdata       : combinational instruction-memory read
//   redirect_valid/redirect_pc : PC load request from execute/trap logic
//   out_valid/out_ready        : decode handshake, carrying out_instr/out_pc
//   fetch_fault                : sticky misaligned/out-of-range indication
// master = fetch unit, slave = memory/decode/redirect side.
interface instr_fetch_if;
  import riscky_pkg::*;

  logic [IMEM_AW-1:0] imem_addr;
  logic [ILEN-1:0]    imem_rdata;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ILEN-1:0]    out_instr;
  logic [XLEN-1:0]    out_pc;
  logic               fetch_fault;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fetch_fault
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small shift-register FIFO of fetch_entry_t.
//   i_push/i_data : enqueue (accepted when not full, or full with a same-cycle pop)
//   i_pop         : dequeue head (ignored when empty)
//   i_flush       : discard all entries; wins over push and pop
//   o_full/o_empty: occupancy flags
//   o_head        : entry 0, always a register; holds its last value when empty
module fetch_fifo
  import riscky_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int unsigned IW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

  fetch_entry_t  r_mem [FQ_DEPTH];
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;
  logic [IW-1:0] w_wr_idx;

  assign o_full    = (r_count == CW'(FQ_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Write slot after the optional shift; only meaningful when w_do_push.
  assign w_wr_idx  = IW'(w_do_pop ? r_count - 1'b1 : r_count);
  assign o_head    = r_mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Storage untouched so the head keeps presenting its last value.
      r_count <= '0;
    end else begin
      // Popping the last entry leaves slot 0 as-is so out_* hold.
      if (w_do_pop) begin
        for (int i = 0; i < FQ_DEPTH - 1; i++) begin
          if (CW'(i + 1) < r_count) begin
            r_mem[i] <= r_mem[i+1];
          end
        end
      end
      if (w_do_push) begin
        r_mem[w_wr_idx] <= i_data;
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch-side initiator for instruction memory.
//   clk, rst_n : core clock, asynchronous active-low reset
//   io_bus     : instr_fetch_if.master -- imem read port, redirect input,
//                decode valid/ready output with {out_pc, out_instr}, fetch_fault
// Owns the PC, pushes {pc, imem_rdata} into a small queue each RUN cycle the
// queue can accept, flushes on redirect and halts on bad fetch addresses.
module instr_fetch
  import riscky_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master io_bus
);

  fetch_state_t    r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic            r_fault, w_fault_next;

  logic            w_push, w_flush, w_pop;
  logic            w_full, w_empty;
  logic            w_pc_ok, w_redir_ok;
  fetch_entry_t    w_push_entry, w_head;

  assign w_pc_ok      = imem_word_ok(r_pc[XLEN-1:2]);
  assign w_redir_ok   = (io_bus.redirect_pc[1:0] == 2'b00) &&
                        imem_word_ok(io_bus.redirect_pc[XLEN-1:2]);
  assign w_pop        = !w_empty && io_bus.out_ready;
  assign w_push_entry = '{pc: r_pc, instr: io_bus.imem_rdata};

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault_next = r_fault;
    w_push       = 1'b0;
    w_flush      = 1'b0;

    if (io_bus.redirect_valid) begin
      // Redirect overrides any push/pop decided this cycle.
      w_flush   = 1'b1;
      w_pc_next = io_bus.redirect_pc;
      if (w_redir_ok) begin
        w_state_next = RUN;
        w_fault_next = 1'b0;
      end else begin
        w_state_next = HALT;
        w_fault_next = 1'b1;
      end
    end else begin
      unique case (r_state)
        BOOT: w_state_next = RUN;
        RUN: begin
          if (!w_pc_ok) begin
            w_state_next = HALT;
            w_fault_next = 1'b1;
          end else if (!w_full || w_pop) begin
            w_push    = 1'b1;
            w_pc_next = r_pc + 32'd4;
          end
        end
        HALT: ;
        default: w_state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_fault <= w_fault_next;
    end
  end

  fetch_fifo #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_push_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign io_bus.imem_addr = r_pc[IMEM_AW+1:2];
  assign io_bus.out_valid = !w_empty;
  assign io_bus.out_instr = w_head.instr;
  assign io_bus.out_pc    = w_head.pc;
  // Raised already in the cycle a RUN-state PC walks off the end of memory.
  assign io_bus.fetch_fault = r_fault || ((r_state == RUN) && !w_pc_ok);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import riscky_pkg::*;

  localparam int unsigned Depth = 2;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (Depth)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Memory word k holds 0x1000_0000 + k; output forced to zero during reset.
  assign bus.imem_rdata = rst_n ? (32'h1000_0000 + 32'(bus.imem_addr)) : 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after rst_n rose (cycle 0 of the table).
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;
  bit          m_boot;
  bit          m_fetch;
  bit          m_fault;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  function automatic bit addr_ok(input logic [31:0] pc);
    return (pc % 4 == 0) && (pc / 4 < IMEM_WORDS);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc         = 32'h0;
    m_last_pc    = 32'h0;
    m_last_instr = 32'h0;
    m_boot       = 1'b1;
    m_fetch      = 1'b1;
    m_fault      = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    bit pop;
    bit push;
    if (rv) begin
      if (m_q.size() != 0) begin
        m_last_pc    = m_q[0];
        m_last_instr = word_of(m_q[0]);
      end
      m_q.delete();
      m_pc    = rpc;
      m_fetch = addr_ok(rpc);
      m_fault = !addr_ok(rpc);
      m_boot  = 1'b0;
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      push = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_fetch) begin
        if (m_pc / 4 >= IMEM_WORDS) begin
          m_fetch = 1'b0;
          m_fault = 1'b1;
        end else begin
          push = (m_q.size() < Depth) || pop;
        end
      end
      if (pop) begin
        m_last_pc    = m_q.pop_front();
        m_last_instr = word_of(m_last_pc);
      end
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    bit          e_fault;
    e_pc    = (m_q.size() != 0) ? m_q[0] : m_last_pc;
    e_instr = (m_q.size() != 0) ? word_of(m_q[0]) : m_last_instr;
    e_fault = m_fault || (m_fetch && !m_boot && (m_pc / 4 >= IMEM_WORDS));
    chk($sformatf("rnd[%0d].valid", cyc), 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk($sformatf("rnd[%0d].pc", cyc), bus.out_pc, e_pc);
    chk($sformatf("rnd[%0d].instr", cyc), bus.out_instr, e_instr);
    chk($sformatf("rnd[%0d].fault", cyc), 32'(bus.fetch_fault), 32'(e_fault));
    chk($sformatf("rnd[%0d].addr", cyc), 32'(bus.imem_addr), 32'(m_pc[5:2]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic        ef;
    logic [3:0]  ea;
  } vec_t;

  vec_t vt[25];

  initial begin
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] exp_pc;
    int          n_out;
    logic [31:0] last_out;
    bit          saw_fault;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1);

    //        rv    rpc         rdy    valid  out_pc      out_instr        fault  addr
    vt[0]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0000_0000, 1'b0, 4'h0};
    vt[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0000_0000, 1'b0, 4'h0};
    vt[2]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 32'h1000_0000, 1'b0, 4'h1};
    vt[3]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 32'h1000_0001, 1'b0, 4'h2};
    vt[4]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 32'h1000_0002, 1'b0, 4'h3};
    vt[5]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h0C, 32'h1000_0003, 1'b0, 4'h4};
    vt[6]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h0C, 32'h1000_0003, 1'b0, 4'h5};
    vt[7]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h0C, 32'h1000_0003, 1'b0, 4'h5};
    vt[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h0C, 32'h1000_0003, 1'b0, 4'h5};
    vt[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 32'h1000_0003, 1'b0, 4'h5};
    vt[10] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 32'h1000_0004, 1'b0, 4'h6};
    vt[11] = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h14, 32'h1000_0005, 1'b0, 4'h7};
    vt[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h14, 32'h1000_0005, 1'b0, 4'h8};
    vt[13] = '{1'b1, 32'h22, 1'b1, 1'b1, 32'h20, 32'h1000_0008, 1'b0, 4'h9};
    vt[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h20, 32'h1000_0008, 1'b1, 4'h8};
    vt[15] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h1000_0008, 1'b1, 4'h8};
    vt[16] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h20, 32'h1000_0008, 1'b0, 4'h4};
    vt[17] = '{1'b1, 32'h30, 1'b1, 1'b1, 32'h10, 32'h1000_0004, 1'b0, 4'h5};
    vt[18] = '{1'b1, 32'h04, 1'b1, 1'b0, 32'h10, 32'h1000_0004, 1'b0, 4'hC};
    vt[19] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h10, 32'h1000_0004, 1'b0, 4'h1};
    vt[20] = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h04, 32'h1000_0001, 1'b0, 4'h2};
    vt[21] = '{1'b1, 32'h3C, 1'b1, 1'b0, 32'h04, 32'h1000_0001, 1'b1, 4'h0};
    vt[22] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h04, 32'h1000_0001, 1'b0, 4'hF};
    vt[23] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h3C, 32'h1000_000F, 1'b1, 4'h0};
    vt[24] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h3C, 32'h1000_000F, 1'b1, 4'h0};

    // Directed table: row k drives inputs for cycle k and checks that cycle's outputs.
    do_reset();
    for (int k = 0; k < 25; k++) begin
      drive(vt[k].rv, vt[k].rpc, vt[k].rdy);
      chk($sformatf("vec[%0d].valid", k), 32'(bus.out_valid), 32'(vt[k].ev));
      chk($sformatf("vec[%0d].pc", k), bus.out_pc, vt[k].epc);
      chk($sformatf("vec[%0d].instr", k), bus.out_instr, vt[k].ei);
      chk($sformatf("vec[%0d].fault", k), 32'(bus.fetch_fault), 32'(vt[k].ef));
      chk($sformatf("vec[%0d].addr", k), 32'(bus.imem_addr), 32'(vt[k].ea));
      tick();
    end

    // Free run from reset to the end of memory: 0..0x3C exactly once, in order.
    do_reset();
    n_out     = 0;
    last_out  = 32'hFFFF_FFFF;
    saw_fault = 1'b0;
    exp_pc    = 32'h0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) begin
        chk($sformatf("run[%0d].pc", c), bus.out_pc, exp_pc);
        exp_pc   = exp_pc + 32'd4;
        last_out = bus.out_pc;
        n_out++;
      end
      if (bus.fetch_fault) saw_fault = 1'b1;
      tick();
    end
    chk("run.count", 32'(n_out), 32'd16);
    chk("run.last_pc", last_out, 32'h3C);
    chk("run.fault_seen", 32'(saw_fault), 32'd1);
    chk("run.fault_end", 32'(bus.fetch_fault), 32'd1);
    chk("run.valid_end", 32'(bus.out_valid), 32'd0);

    // Reset asserted mid-stream clears outputs without waiting for a clock edge.
    do_reset();
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.pc", bus.out_pc, 32'h0);
    chk("rst.instr", bus.out_instr, 32'h0);
    chk("rst.fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst.addr", 32'(bus.imem_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rst.c0.valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("rst.c1.valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("rst.c2.valid", 32'(bus.out_valid), 32'd1);
    chk("rst.c2.pc", bus.out_pc, 32'h0);
    chk("rst.c2.instr", bus.out_instr, 32'h1000_0000);

    // Randomised traffic against the queue-level reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 95))
                                        : 32'($urandom_range(0, 15)) * 32'd4;
      rdy = ($urandom_range(0, 3) != 0);
      drive(rv, rpc, rdy);
      model_check(c);
      tick();
      model_step(rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch-side initiator for the instruction memory.
- Owns the PC, drives the word index to instruction memory, and captures the returned instruction together with its PC.
- Queues fetched instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) with flush, and flags misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- FQ_DEPTH, 2, fetch-queue entries; power of two, >= 2.
- XLEN, ILEN, IMEM_AW, IMEM_WORDS come from riscky_pkg and are not module parameters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- imem_addr  out  IMEM_AW  word index to instruction memory, equal to pc[IMEM_AW+1:2]; combinational from the PC register.
- imem_rdata  in  ILEN  instruction from memory; combinational, same cycle as imem_addr.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  XLEN  redirect target byte address.
- out_valid  out  1  head of queue valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  ILEN  head instruction.
- out_pc  out  XLEN  head PC.
- fetch_fault  out  1  sticky fault: misaligned or out-of-range PC.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, queue empty, state=BOOT.
  - out_valid=0, out_instr=0, out_pc=0, fetch_fault=0.
- States BOOT, RUN, HALT:
  - BOOT: one cycle after rst_n rises, then RUN. No fetch in BOOT, because memory output is forced to zero while in reset.
  - RUN: a push occurs when the queue is not full, or when it is full and a pop happens the same cycle.
    - Push stores {pc, imem_rdata}; pc <= pc+4.
    - Fetch latency: instruction at PC p is visible on out_* the cycle after its push.
    - First out_valid appears 2 cycles after rst_n rises.
  - Range check in RUN: if pc word index >= IMEM_WORDS, no push; go to HALT and set fetch_fault. Queued entries still drain.
  - HALT: no pushes; pc frozen. Leaves only via a valid redirect or reset.
- Pop occurs when out_valid && out_ready.
  - out_* come straight from registered queue storage.
  - out_instr and out_pc are stable while out_valid && !out_ready.
- Redirect (highest priority; overrides push and pop in the same cycle):
  - Queue is flushed; out_valid=0 the next cycle; no push that cycle; pc <= redirect_pc.
  - If redirect_pc[1:0]!=0 or the word index is out of range: state=HALT and fetch_fault=1.
  - Otherwise: state=RUN and fetch_fault=0.
- Back-to-back redirects: the last one wins each cycle.
- Arithmetic: pc+4 is modulo 2^XLEN. The range check stops fetch before the wrap is ever consumed.
- Queue: full at FQ_DEPTH entries; no push when full unless a pop happens in the same cycle. Empty: out_valid=0 and out_* hold their last values.
- Simultaneous push and pop on a full queue: count unchanged, order preserved.
- Reset mid-operation: all state clears immediately (asynchronously). Fetch restarts at RESET_PC through BOOT.

Decomposition:
- riscky_pkg additions:
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - fetch_entry_t struct {pc[XLEN], instr[ILEN]}.
  - FQ_DEPTH_DEFAULT constant.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and head outputs. Flush has priority over push and pop.

Test Plan:
All scenarios use IMEM_WORDS=16 and memory word k = 32'h1000_0000+k.
1. Release reset, out_ready=1 -> out_valid rises on cycle 2. out_pc/out_instr go 0/10000000, 4/10000001, 8/10000002 on consecutive cycles.
2. out_ready=0 for 6 cycles after first valid -> queue holds 2 entries and imem_addr stays 2. Head holds pc 0. After release, out_pc 0,4,8,C with no gaps or duplicates.
3. While streaming, redirect_pc=0x20 with out_ready=1 -> next cycle out_valid=0 and the same-cycle pop is discarded. Next cycle out_pc=0x20, out_instr=10000008.
4. redirect_pc=0x22 -> fetch_fault=1, out_valid=0, imem_addr frozen. Then redirect_pc=0x10 -> fetch_fault=0 and out_pc=0x10 two cycles later.
5. Free-run from 0 -> last out_pc=0x3C. fetch_fault=1 the cycle pc reaches 0x40. PC 0x40 is never output.
6. Assert rst_n=0 mid-stream -> outputs clear immediately. After release, the stream restarts at out_pc=0 on cycle 2.
